rr_arbiter8: RTL and testbench

Round-robin arbiter that shares one resource among 8 requesters. It encodes the winner to a 3-bit index using the same code as encoder8to3 (input i<n> maps to y = n). It also enforces a maximum hold time per grant. It sits between the 8 requester request lines and the shared resource's select/mux input.

---
 rtl/rr_arbiter8.sv | 110 +++++++++++
 tb/tb_rr_arbiter8.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/rr_arbiter8.sv
// Round-robin arbiter for 8 requesters with encoded winner index and an
// optional per-grant maximum hold time; all outputs are registered.
module rr_arbiter8 #(
  parameter int unsigned MAX_HOLD = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] req,
  input  logic       rel,
  output logic [7:0] gnt,
  output logic [2:0] gnt_idx,
  output logic       gnt_vld,
  output logic       timeout
);

  localparam int unsigned N  = 8;
  localparam int unsigned IW = 3;
  localparam int unsigned CW = 8;

  typedef enum logic {
    IDLE,
    GRANT
  } state_t;

  state_t         state, state_nxt;
  logic [IW-1:0]  ptr, ptr_nxt;
  logic [CW-1:0]  hold_cnt, hold_nxt;
  logic [N-1:0]   gnt_nxt;
  logic [IW-1:0]  idx_nxt;
  logic           vld_nxt;
  logic           timeout_nxt;

  logic [IW-1:0]  pick_idx;
  logic           pick_vld;
  logic           rel_end, drop_end, tmo_end;

  // Rotating priority scan; walking downward leaves the closest-to-ptr hit last.
  always_comb begin
    pick_vld = 1'b0;
    pick_idx = '0;
    for (int k = N - 1; k >= 0; k--) begin
      if (req[IW'(ptr + IW'(k))]) begin
        pick_vld = 1'b1;
        pick_idx = IW'(ptr + IW'(k));
      end
    end
  end

  assign rel_end  = rel;
  assign drop_end = ~req[gnt_idx];
  assign tmo_end  = (MAX_HOLD != 0) && (hold_cnt == CW'(MAX_HOLD));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      ptr      <= '0;
      hold_cnt <= '0;
      gnt      <= '0;
      gnt_idx  <= '0;
      gnt_vld  <= 1'b0;
      timeout  <= 1'b0;
    end else begin
      state    <= state_nxt;
      ptr      <= ptr_nxt;
      hold_cnt <= hold_nxt;
      gnt      <= gnt_nxt;
      gnt_idx  <= idx_nxt;
      gnt_vld  <= vld_nxt;
      timeout  <= timeout_nxt;
    end
  end

  always_comb begin
    state_nxt   = state;
    ptr_nxt     = ptr;
    hold_nxt    = hold_cnt;
    gnt_nxt     = gnt;
    idx_nxt     = gnt_idx;
    vld_nxt     = gnt_vld;
    timeout_nxt = 1'b0;

    unique case (state)
      IDLE: begin
        if (pick_vld) begin
          state_nxt = GRANT;
          gnt_nxt   = N'(1) << pick_idx;
          idx_nxt   = pick_idx;
          vld_nxt   = 1'b1;
          hold_nxt  = CW'(1);
        end
      end
      GRANT: begin
        if (rel_end || drop_end || tmo_end) begin
          state_nxt   = IDLE;
          gnt_nxt     = '0;
          idx_nxt     = '0;
          vld_nxt     = 1'b0;
          hold_nxt    = '0;
          ptr_nxt     = IW'(gnt_idx + IW'(1));
          // Flag expiry only when nothing else would have ended the grant.
          timeout_nxt = tmo_end && !rel_end && !drop_end;
        end else if (hold_cnt != '1) begin
          hold_nxt = hold_cnt + CW'(1);
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

endmodule

// File: tb/tb_rr_arbiter8.sv
// Self-checking bench for rr_arbiter8: directed scenarios plus randomized
// traffic compared against a cycle-level behavioural model.
module tb_rr_arbiter8;

  localparam int unsigned MAX_HOLD = 16;

  logic       clk;
  logic       rst_n;
  logic [7:0] req;
  logic       rel;
  logic [7:0] gnt;
  logic [2:0] gnt_idx;
  logic       gnt_vld;
  logic       timeout;

  int checks = 0;
  int errors = 0;

  // Behavioural model: who owns the resource, for how long, and where the scan starts.
  bit m_busy;
  int m_owner;
  int m_ptr;
  int m_hold;
  bit m_timeout;

  rr_arbiter8 #(.MAX_HOLD(MAX_HOLD)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .req     (req),
    .rel     (rel),
    .gnt     (gnt),
    .gnt_idx (gnt_idx),
    .gnt_vld (gnt_vld),
    .timeout (timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic void model_reset();
    m_busy = 0; m_owner = 0; m_ptr = 0; m_hold = 0; m_timeout = 0;
  endfunction

  function automatic void model_edge(input logic [7:0] r, input logic l);
    if (!m_busy) begin
      m_timeout = 0;
      for (int k = 0; k < 8; k++) begin
        int cand;
        cand = (m_ptr + k) % 8;
        if (r[cand] && !m_busy) begin
          m_busy = 1; m_owner = cand; m_hold = 1;
        end
      end
    end else begin
      bit by_rel, by_drop, by_tmo;
      by_rel  = l;
      by_drop = !r[m_owner];
      by_tmo  = (MAX_HOLD != 0) && (m_hold == int'(MAX_HOLD));
      if (by_rel || by_drop || by_tmo) begin
        m_busy = 0;
        m_ptr = (m_owner + 1) % 8;
        m_timeout = by_tmo && !by_rel && !by_drop;
      end else begin
        m_hold = m_hold + 1;
        m_timeout = 0;
      end
    end
  endfunction

  function automatic logic [12:0] exp_vec();
    logic [7:0] g;
    g = m_busy ? 8'(1 << m_owner) : 8'h00;
    return {g, m_busy ? 3'(m_owner) : 3'd0, m_busy, m_timeout};
  endfunction

  // Present inputs, take one edge, advance the model, settle just after the edge.
  task automatic step(input logic [7:0] r, input logic l);
    req = r;
    rel = l;
    @(posedge clk);
    model_edge(r, l);
    #1;
  endtask

  task automatic apply_reset();
    req = 8'h00; rel = 1'b0;
    rst_n = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; req = 8'h00; rel = 1'b0;
    model_reset();
    #3;
    checks++;
    if ({gnt, gnt_idx, gnt_vld, timeout} !== 13'h0) begin
      errors++; $display("FAIL reset_state got=%h want=0", {gnt, gnt_idx, gnt_vld, timeout});
    end
    @(posedge clk); #1 rst_n = 1'b1;
    step(8'h01, 1'b0);
    checks++;
    if ({gnt, gnt_idx, gnt_vld} !== {8'h01, 3'd0, 1'b1}) begin
      errors++; $display("FAIL first_grant got=%h/%0d/%b want=01/0/1", gnt, gnt_idx, gnt_vld);
    end
    step(8'h01, 1'b0);
    #2 rst_n = 1'b0;
    #1;
    model_reset();
    checks++;
    if ({gnt, gnt_idx, gnt_vld, timeout} !== 13'h0) begin
      errors++; $display("FAIL async_reset_midgrant got=%h want=0", {gnt, gnt_idx, gnt_vld, timeout});
    end
    #1 rst_n = 1'b1;
  endtask

  task automatic test_single();
    apply_reset();
    step(8'h10, 1'b0);
    checks++;
    if ({gnt, gnt_idx, gnt_vld} !== {8'h10, 3'd4, 1'b1}) begin
      errors++; $display("FAIL single_grant got=%h/%0d/%b want=10/4/1", gnt, gnt_idx, gnt_vld);
    end
    step(8'h10, 1'b1);
    checks++;
    if ({gnt_vld, timeout} !== 2'b00) begin
      errors++; $display("FAIL single_release vld/timeout got=%b%b want=00", gnt_vld, timeout);
    end
    step(8'hFF, 1'b0);
    checks++;
    if ({gnt, gnt_idx} !== {8'h20, 3'd5}) begin
      errors++; $display("FAIL single_next_ptr got=%h/%0d want=20/5", gnt, gnt_idx);
    end
  endtask

  task automatic test_fairness();
    apply_reset();
    for (int i = 0; i < 9; i++) begin
      step(8'hFF, 1'b0);
      checks++;
      if ({gnt_idx, gnt_vld} !== {3'(i % 8), 1'b1}) begin
        errors++; $display("FAIL fair_idx[%0d] got=%0d/%b want=%0d/1", i, gnt_idx, gnt_vld, i % 8);
      end
      step(8'hFF, 1'b0);
      checks++;
      if (gnt_vld !== 1'b1) begin
        errors++; $display("FAIL fair_second_cycle[%0d] got=%b want=1", i, gnt_vld);
      end
      step(8'hFF, 1'b1);
      checks++;
      if ({gnt, gnt_vld} !== 9'h0) begin
        errors++; $display("FAIL fair_gap[%0d] got=%h/%b want=00/0", i, gnt, gnt_vld);
      end
    end
  endtask

  task automatic test_timeout();
    int len;
    apply_reset();
    step(8'h80, 1'b0);
    len = 0;
    for (int c = 0; c < 40 && gnt_vld; c++) begin
      checks++;
      if (timeout !== 1'b0) begin
        errors++; $display("FAIL tmo_early cycle=%0d got=%b want=0", c, timeout);
      end
      len++;
      step(8'h80, 1'b0);
    end
    checks++;
    if (len != int'(MAX_HOLD)) begin
      errors++; $display("FAIL tmo_length got=%0d want=%0d", len, MAX_HOLD);
    end
    checks++;
    if ({gnt_vld, timeout} !== 2'b01) begin
      errors++; $display("FAIL tmo_pulse vld/timeout got=%b%b want=01", gnt_vld, timeout);
    end
    step(8'h80, 1'b0);
    checks++;
    if ({gnt, gnt_idx, gnt_vld, timeout} !== {8'h80, 3'd7, 1'b1, 1'b0}) begin
      errors++; $display("FAIL tmo_regrant got=%h/%0d/%b/%b want=80/7/1/0", gnt, gnt_idx, gnt_vld, timeout);
    end
  endtask

  task automatic test_drop_and_simul();
    apply_reset();
    step(8'h08, 1'b0);
    repeat (4) step(8'h08, 1'b0);
    step(8'h00, 1'b0);
    checks++;
    if ({gnt_vld, timeout} !== 2'b00) begin
      errors++; $display("FAIL drop_end vld/timeout got=%b%b want=00", gnt_vld, timeout);
    end
    apply_reset();
    step(8'h02, 1'b0);
    repeat (MAX_HOLD - 1) step(8'h02, 1'b0);
    checks++;
    if (gnt_vld !== 1'b1) begin
      errors++; $display("FAIL simul_still_held got=%b want=1", gnt_vld);
    end
    step(8'h02, 1'b1);
    checks++;
    if ({gnt_vld, timeout} !== 2'b00) begin
      errors++; $display("FAIL simul_rel_tmo vld/timeout got=%b%b want=00", gnt_vld, timeout);
    end
  endtask

  task automatic test_wrap();
    apply_reset();
    step(8'h40, 1'b0);
    step(8'h40, 1'b1);
    step(8'h21, 1'b0);
    checks++;
    if ({gnt, gnt_idx} !== {8'h01, 3'd0}) begin
      errors++; $display("FAIL wrap_scan got=%h/%0d want=01/0", gnt, gnt_idx);
    end
  endtask

  task automatic test_random();
    logic [7:0] r;
    logic       l;
    apply_reset();
    r = 8'h00;
    for (int c = 0; c < 600; c++) begin
      if ($urandom_range(3, 0) == 0) r = 8'($urandom);
      l = ($urandom_range(9, 0) == 0);
      step(r, l);
      checks++;
      if ({gnt, gnt_idx, gnt_vld, timeout} !== exp_vec()) begin
        errors++;
        $display("FAIL random cycle=%0d got=%h/%0d/%b/%b want=%h", c, gnt, gnt_idx, gnt_vld, timeout, exp_vec());
      end
    end
  endtask

  initial begin
    req = 8'h00; rel = 1'b0; rst_n = 1'b0;
    test_reset();
    test_single();
    test_fairness();
    test_timeout();
    test_drop_and_simul();
    test_wrap();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
